exc_redirect_ctrl: RTL and testbench

- Sequences the pipeline response to an exception or ERET once the exception logic in the writeback stage has decided one.
- Waits for any outstanding cache/memory transaction to drain, issues a one-cycle CP0 commit and a full pipeline flush, then drives the redirect PC to the fetch stage under a valid/ready handshake.
- Also owns the interrupt front end: it synchronises the six external hardware interrupt lines and generates the Count/Compare timer interrupt. The result feeds the exception logic's hardware_abortion input.

---
 rtl/exc_redirect_ctrl_pkg.sv | 17 +
 rtl/exc_redirect_ctrl_if.sv | 21 ++
 rtl/exc_redirect_ctrl_cp0_timer.sv | 63 ++++++
 rtl/exc_redirect_ctrl.sv | 104 ++++++++++
 tb/tb_exc_redirect_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/exc_redirect_ctrl_pkg.sv
// Shared types and constants for the exception/ERET redirect sequencer.
// Holds the FSM encoding, the event kind and the exception vector.
package exc_redirect_ctrl_pkg;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DRAIN    = 2'd1;
  localparam logic [1:0] ST_COMMIT   = 2'd2;
  localparam logic [1:0] ST_REDIRECT = 2'd3;

  typedef enum logic {
    KIND_EXC  = 1'b0,
    KIND_ERET = 1'b1
  } kind_e;

endpackage

// File: rtl/exc_redirect_ctrl_if.sv
// Redirect handshake from the sequencer to the fetch stage.
// The master drives the target PC; the fetch stage returns ready.
interface exc_redirect_ctrl_if;

  logic        valid;
  logic [31:0] pc;
  logic        ready;

  modport master (
    output valid,
    output pc,
    input  ready
  );

  modport slave (
    input  valid,
    input  pc,
    output ready
  );

endinterface

// File: rtl/exc_redirect_ctrl_cp0_timer.sv
// CP0 Count/Compare timer: Count ticks every second cycle,
// pending latches on a match and clears on a Compare write.
module exc_redirect_ctrl_cp0_timer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        pend_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic        div_q, div_d;
  logic        pend_q, pend_d;
  logic        cnt_upd;

  always_comb begin
    count_d = count_q;
    cmp_d   = cmp_q;
    div_d   = ~div_q;
    cnt_upd = 1'b0;
    if (count_we_i) begin
      count_d = wdata_i;
      div_d   = 1'b0;
      cnt_upd = 1'b1;
    end else if (div_q) begin
      count_d = count_q + 32'd1;
      cnt_upd = 1'b1;
    end
    if (compare_we_i) begin
      cmp_d = wdata_i;
    end
    // A Compare write clears pending even if it also matches
    pend_d = pend_q;
    if (compare_we_i) begin
      pend_d = 1'b0;
    end else if (cnt_upd && (count_d == cmp_q)) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      cmp_q   <= '0;
      div_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = cmp_q;
  assign pend_o    = pend_q;

endmodule

// File: rtl/exc_redirect_ctrl.sv
// Exception/ERET redirect sequencer plus interrupt front end:
// drain, commit+flush, then redirect fetch under valid/ready.
module exc_redirect_ctrl
  import exc_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEF,
  parameter int          SYNC_STAGES = 2,
  parameter int          HW_INT_W    = 6
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                exc_valid_i,
  input  logic                eret_valid_i,
  input  logic [31:0]         epc_i,
  input  logic                mem_busy_i,
  exc_redirect_ctrl_if.master redir,
  input  logic [HW_INT_W-1:0] hw_int_raw_i,
  input  logic                count_we_i,
  input  logic                compare_we_i,
  input  logic [31:0]         cp0_wdata_i,
  output logic                busy_o,
  output logic                cp0_commit_o,
  output logic                flush_all_o,
  output logic [HW_INT_W-1:0] hw_int_o,
  output logic [31:0]         count_o,
  output logic [31:0]         compare_o
);

  logic [1:0]  state_q, state_d;
  logic [31:0] tgt_q, tgt_d;
  kind_e       kind_q, kind_d;
  logic        timer_pend;

  logic [HW_INT_W-1:0] sync_q [SYNC_STAGES];

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    kind_d  = kind_q;
    unique case (state_q)
      ST_IDLE: begin
        if (exc_valid_i || eret_valid_i) begin
          tgt_d   = exc_valid_i ? EXC_VECTOR : epc_i;
          kind_d  = exc_valid_i ? KIND_EXC : KIND_ERET;
          state_d = mem_busy_i ? ST_DRAIN : ST_COMMIT;
        end
      end
      ST_DRAIN: begin
        if (!mem_busy_i) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (redir.ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      tgt_q   <= '0;
      kind_q  <= KIND_EXC;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      kind_q  <= kind_d;
    end
  end

  // Strobes decode straight from state so reset kills them at once
  assign busy_o       = (state_q != ST_IDLE);
  assign flush_all_o  = (state_q == ST_COMMIT);
  assign cp0_commit_o = (state_q == ST_COMMIT) &&
                        (kind_q == KIND_EXC);
  assign redir.valid  = (state_q == ST_REDIRECT);
  assign redir.pc     = (state_q == ST_REDIRECT) ? tgt_q : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= hw_int_raw_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  exc_redirect_ctrl_cp0_timer u_timer (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .count_we_i   (count_we_i),
    .compare_we_i (compare_we_i),
    .wdata_i      (cp0_wdata_i),
    .count_o      (count_o),
    .compare_o    (compare_o),
    .pend_o       (timer_pend)
  );

  assign hw_int_o = sync_q[SYNC_STAGES-1] |
                    {timer_pend, {(HW_INT_W-1){1'b0}}};

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Directed bench for exc_redirect_ctrl: sequencing, timer,
// synchroniser and asynchronous reset behaviour.
module tb_exc_redirect_ctrl;

  logic        clk;
  logic        rst_n;
  logic        exc_valid;
  logic        eret_valid;
  logic [31:0] epc;
  logic        mem_busy;
  logic [5:0]  hw_int_raw;
  logic        count_we;
  logic        compare_we;
  logic [31:0] wdata;
  logic        busy;
  logic        cp0_commit;
  logic        flush_all;
  logic [5:0]  hw_int;
  logic [31:0] count;
  logic [31:0] compare;

  int tests = 0;
  int fails = 0;

  exc_redirect_ctrl_if redir ();

  exc_redirect_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .exc_valid_i  (exc_valid),
    .eret_valid_i (eret_valid),
    .epc_i        (epc),
    .mem_busy_i   (mem_busy),
    .redir        (redir),
    .hw_int_raw_i (hw_int_raw),
    .count_we_i   (count_we),
    .compare_we_i (compare_we),
    .cp0_wdata_i  (wdata),
    .busy_o       (busy),
    .cp0_commit_o (cp0_commit),
    .flush_all_o  (flush_all),
    .hw_int_o     (hw_int),
    .count_o      (count),
    .compare_o    (compare)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    exc_valid   = 1'b0;
    eret_valid  = 1'b0;
    epc         = '0;
    mem_busy    = 1'b0;
    redir.ready = 1'b1;
    hw_int_raw  = '0;
    count_we    = 1'b0;
    compare_we  = 1'b0;
    wdata       = '0;

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_commit", cp0_commit, 0);
    chk("rst_flush", flush_all, 0);
    chk("rst_rvalid", redir.valid, 0);
    chk("rst_rpc", redir.pc, 0);
    chk("rst_count", count, 0);
    chk("rst_compare", compare, 0);
    chk("rst_hwint", hw_int, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // exception, minimum latency
    exc_valid = 1'b1;
    tick();
    exc_valid = 1'b0;
    chk("e1_commit", cp0_commit, 1);
    chk("e1_flush", flush_all, 1);
    chk("e1_busy", busy, 1);
    chk("e1_rvalid_c", redir.valid, 0);
    tick();
    chk("e1_rvalid", redir.valid, 1);
    chk("e1_rpc", redir.pc, 32'hBFC00380);
    chk("e1_commit_r", cp0_commit, 0);
    chk("e1_flush_r", flush_all, 0);
    tick();
    chk("e1_busy_idle", busy, 0);
    chk("e1_rvalid_idle", redir.valid, 0);
    chk("e1_rpc_idle", redir.pc, 0);

    // ERET with a 5-cycle drain
    eret_valid = 1'b1;
    epc        = 32'h80001234;
    mem_busy   = 1'b1;
    tick();
    eret_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("e2_drain_busy", busy, 1);
      chk("e2_drain_flush", flush_all, 0);
      chk("e2_drain_rvalid", redir.valid, 0);
      if (i == 4) mem_busy = 1'b0;
      tick();
    end
    chk("e2_flush", flush_all, 1);
    chk("e2_commit", cp0_commit, 0);
    tick();
    chk("e2_rvalid", redir.valid, 1);
    chk("e2_rpc", redir.pc, 32'h80001234);
    tick();
    chk("e2_idle", busy, 0);

    // simultaneous exc+eret, fetch stalls 3 cycles
    exc_valid   = 1'b1;
    eret_valid  = 1'b1;
    redir.ready = 1'b0;
    tick();
    exc_valid  = 1'b0;
    eret_valid = 1'b0;
    chk("e3_commit", cp0_commit, 1);
    tick();
    exc_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("e3_rvalid", redir.valid, 1);
      chk("e3_rpc", redir.pc, 32'hBFC00380);
      chk("e3_commit_r", cp0_commit, 0);
      if (i == 3) redir.ready = 1'b1;
      tick();
    end
    exc_valid = 1'b0;
    chk("e3_idle", busy, 0);
    chk("e3_idle_rvalid", redir.valid, 0);
    tick();
    chk("e3_ignored", busy, 0);

    // timer wrap and compare clear
    chk("t_pre_hwint", hw_int, 0);
    count_we = 1'b1;
    wdata    = 32'hFFFFFFFE;
    tick();
    count_we = 1'b0;
    chk("t_load", count, 32'hFFFFFFFE);
    chk("t_load_int", hw_int, 0);
    tick();
    chk("t_c1", count, 32'hFFFFFFFE);
    tick();
    chk("t_c2", count, 32'hFFFFFFFF);
    tick();
    chk("t_c3", count, 32'hFFFFFFFF);
    chk("t_c3_int", hw_int, 0);
    tick();
    chk("t_wrap", count, 0);
    chk("t_wrap_int", hw_int, 6'b100000);
    tick();
    chk("t_hold_int", hw_int, 6'b100000);
    compare_we = 1'b1;
    wdata      = 32'h00000040;
    tick();
    compare_we = 1'b0;
    chk("t_clr_int", hw_int, 0);
    chk("t_compare", compare, 32'h00000040);

    // synchroniser latency
    hw_int_raw = 6'b000001;
    tick();
    chk("s_stage1", hw_int, 0);
    tick();
    chk("s_stage2", hw_int, 6'b000001);
    hw_int_raw = '0;
    repeat (2) tick();
    chk("s_clear", hw_int, 0);

    // async reset in DRAIN
    hw_int_raw = 6'b000010;
    eret_valid = 1'b1;
    epc        = 32'h80000010;
    mem_busy   = 1'b1;
    tick();
    eret_valid = 1'b0;
    tick();
    chk("r1_drain", busy, 1);
    chk("r1_sync", hw_int, 6'b000010);
    #2 rst_n = 1'b0;
    #1;
    chk("r1_busy", busy, 0);
    chk("r1_rvalid", redir.valid, 0);
    chk("r1_count", count, 0);
    chk("r1_compare", compare, 0);
    chk("r1_hwint", hw_int, 0);
    hw_int_raw = '0;
    mem_busy   = 1'b0;
    #3 rst_n = 1'b1;
    tick();

    // async reset in REDIRECT
    exc_valid   = 1'b1;
    redir.ready = 1'b0;
    tick();
    exc_valid = 1'b0;
    tick();
    chk("r2_rvalid_pre", redir.valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("r2_rvalid", redir.valid, 0);
    chk("r2_rpc", redir.pc, 0);
    chk("r2_busy", busy, 0);
    chk("r2_flush", flush_all, 0);
    chk("r2_commit", cp0_commit, 0);
    #3 rst_n = 1'b1;
    redir.ready = 1'b1;
    tick();
    tick();
    chk("r2_no_replay", busy, 0);
    chk("r2_no_flush", flush_all, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
